game_control_fsm: RTL
=====================

Name: game_control_fsm

Overview:
- Top-level game sequencer that sits directly upstream of the game data path.
- Drives the one-hot phase controls (wait_start, stage_N_begin/draw_tower/in_progress/done, win, game_over) that the data path consumes.
- Advances on the data path's completion feedback (start_display_done, stage_N_*_done, game_over_feedback) and the player start key.
- Adds start-key edge detection and an optional per-stage play watchdog.

Parameters:
- PLAY_TIMEOUT, 0, cycles allowed in any PLAY state before forced game over; 0 disables the watchdog.
- TIMER_W, 32, width of the watchdog counter; must satisfy PLAY_TIMEOUT < 2^TIMER_W.

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- start  in  1  player start/continue key, active-high level, synchronous to clk
- start_display_done  in  1  title screen fully drawn
- stage_1_begin_done, stage_2_begin_done, stage_3_begin_done  in  1 each  stage intro screen drawn
- stage_1_tower_done, stage_2_tower_done, stage_3_tower_done  in  1 each  tower placement finished
- stage_1_car_done, stage_2_car_done, stage_3_car_done  in  1 each  all cars of stage destroyed
- stage_1_end_display_done, stage_2_end_display_done, stage_3_end_display_done  in  1 each  stage-clear screen drawn
- game_over_feedback  in  1  a car reached the exit
- wait_start  out  1  title phase
- stage_1_begin, stage_2_begin, stage_3_begin  out  1 each  intro phase
- stage_1_draw_tower, stage_2_draw_tower, stage_3_draw_tower  out  1 each  tower placement phase
- stage_1_in_progress, stage_2_in_progress, stage_3_in_progress  out  1 each  play phase
- stage_1_done, stage_2_done, stage_3_done  out  1 each  stage-clear phase
- win  out  1  terminal win phase
- game_over  out  1  terminal loss phase
- stage_num  out  2  current stage: 0 = none, 1..3 = stage
- timeout_flag  out  1  sticky; set when the last game over was caused by the watchdog

Behaviour:
- Reset (async, resetn=0):
  - state = S_WAIT_START, so wait_start=1 and all other phase outputs are 0.
  - stage_num=0, timeout_flag=0, watchdog counter=0, start_q=0.
- Start edge detection:
  - start_q <= start each cycle.
  - start_rise = start & ~start_q.
  - A level held high counts once only.
- State register and outputs:
  - Moore machine; each phase output is decoded from the registered state.
  - Exactly one phase output is high in every cycle after reset.
  - Response latency: a qualifying input sampled at edge k changes the outputs after edge k.
  - Done inputs are ignored in every state except the one that consumes them.
- Transitions, with stage N = 1..3:
  - S_WAIT_START -> S_BEGIN1 when start_display_done & start_rise. A start_rise before the display is done is discarded, not queued.
  - S_BEGIN_N -> S_TOWER_N when stage_N_begin_done.
  - S_TOWER_N -> S_PLAY_N when stage_N_tower_done.
  - S_PLAY_N -> S_GAME_OVER when game_over_feedback. This has priority over a simultaneous stage_N_car_done.
  - S_PLAY_N -> S_GAME_OVER when the watchdog expires; this sets timeout_flag.
  - S_PLAY_N -> S_DONE_N when stage_N_car_done.
  - S_DONE_N -> S_BEGIN_(N+1) when stage_N_end_display_done & start_rise, for N < 3.
  - S_DONE_3 -> S_WIN when stage_3_end_display_done. No key press is needed.
  - S_WIN or S_GAME_OVER -> S_WAIT_START on start_rise. timeout_flag clears on this transition.
- stage_num:
  - Set to N on entry to S_BEGIN_N; held through DONE_N.
  - Held in WIN/GAME_OVER; cleared to 0 in WAIT_START.
- Watchdog (only when PLAY_TIMEOUT > 0):
  - The counter clears on any entry to a PLAY state and increments each cycle while in PLAY.
  - Expiry occurs in the cycle where counter == PLAY_TIMEOUT-1 and neither game_over_feedback nor car_done is high.
  - If car_done is high in that same cycle, stage clear wins.
  - The counter holds 0 outside PLAY states.
- Illegal or unused state encodings recover to S_WAIT_START on the next edge.
- Reset asserted mid-game returns immediately (asynchronously) to the reset values. The data path sees all in_progress signals drop and resets its car/laser logic.

Test Plan:
- Reset then idle 10 cycles -> wait_start=1, all others 0, stage_num=0. Pulse start before start_display_done -> no transition. Raise start_display_done, then pulse start -> stage_1_begin=1 on the next cycle, stage_num=1.
- Full happy path, PLAY_TIMEOUT=0: feed the begin/tower/car/end-display dones for stages 1-3, with a start pulse after stages 1 and 2 -> outputs visit BEGIN1..DONE3 in order, then win=1 with stage_num=3. A start pulse then -> wait_start=1, stage_num=0.
- In S_PLAY2, assert game_over_feedback and stage_2_car_done in the same cycle -> game_over=1, stage_2_done never asserted, timeout_flag=0.
- PLAY_TIMEOUT=100: enter S_PLAY1 and withhold the dones -> stage_1_in_progress high for exactly 100 cycles, then game_over=1 and timeout_flag=1. A start pulse -> wait_start=1, timeout_flag=0.
- Hold start high across the S_DONE1 entry with stage_1_end_display_done=1 -> stays in S_DONE1 until start falls and rises again.
- Assert resetn=0 asynchronously mid S_TOWER3 -> wait_start=1 and stage_3_draw_tower=0 before the next clk edge; stage_num=0.

Source files
------------

// File: rtl/game_control_fsm.sv
// Top-level game sequencer: steps the data path through title, three stages
// (intro, tower placement, play, stage clear) and the win/loss end screens.
module game_control_fsm #(
  parameter int unsigned PLAY_TIMEOUT = 0,
  parameter int unsigned TIMER_W      = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       start_display_done,
  input  logic       stage_1_begin_done,
  input  logic       stage_2_begin_done,
  input  logic       stage_3_begin_done,
  input  logic       stage_1_tower_done,
  input  logic       stage_2_tower_done,
  input  logic       stage_3_tower_done,
  input  logic       stage_1_car_done,
  input  logic       stage_2_car_done,
  input  logic       stage_3_car_done,
  input  logic       stage_1_end_display_done,
  input  logic       stage_2_end_display_done,
  input  logic       stage_3_end_display_done,
  input  logic       game_over_feedback,
  output logic       wait_start,
  output logic       stage_1_begin,
  output logic       stage_2_begin,
  output logic       stage_3_begin,
  output logic       stage_1_draw_tower,
  output logic       stage_2_draw_tower,
  output logic       stage_3_draw_tower,
  output logic       stage_1_in_progress,
  output logic       stage_2_in_progress,
  output logic       stage_3_in_progress,
  output logic       stage_1_done,
  output logic       stage_2_done,
  output logic       stage_3_done,
  output logic       win,
  output logic       game_over,
  output logic [1:0] stage_num,
  output logic       timeout_flag
);

  typedef enum logic [3:0] {
    S_WAIT_START = 4'd0,
    S_BEGIN1     = 4'd1,
    S_BEGIN2     = 4'd2,
    S_BEGIN3     = 4'd3,
    S_TOWER1     = 4'd4,
    S_TOWER2     = 4'd5,
    S_TOWER3     = 4'd6,
    S_PLAY1      = 4'd7,
    S_PLAY2      = 4'd8,
    S_PLAY3      = 4'd9,
    S_DONE1      = 4'd10,
    S_DONE2      = 4'd11,
    S_DONE3      = 4'd12,
    S_WIN        = 4'd13,
    S_GAME_OVER  = 4'd14
  } state_t;

  localparam bit                 WD_EN   = (PLAY_TIMEOUT != 0);
  localparam logic [TIMER_W-1:0] WD_LAST = TIMER_W'(WD_EN ? PLAY_TIMEOUT - 1 : 0);

  state_t               state, next_state;
  logic                 start_q, start_rise;
  logic [TIMER_W-1:0]   wd_cnt;
  logic                 in_play, next_in_play, wd_expire, wd_fire;
  logic [3:1]           begin_done, tower_done, car_done, end_done;

  assign begin_done = {stage_3_begin_done, stage_2_begin_done, stage_1_begin_done};
  assign tower_done = {stage_3_tower_done, stage_2_tower_done, stage_1_tower_done};
  assign car_done   = {stage_3_car_done, stage_2_car_done, stage_1_car_done};
  assign end_done   = {stage_3_end_display_done, stage_2_end_display_done,
                       stage_1_end_display_done};

  // A held key produces one rise only; the level must drop before it counts again.
  assign start_rise   = start & ~start_q;
  assign in_play      = (state == S_PLAY1) || (state == S_PLAY2) || (state == S_PLAY3);
  assign next_in_play = (next_state == S_PLAY1) || (next_state == S_PLAY2) ||
                        (next_state == S_PLAY3);
  assign wd_expire    = WD_EN && in_play && (wd_cnt == WD_LAST);

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    wd_fire    = 1'b0;
    case (state)
      S_WAIT_START: if (start_display_done && start_rise) next_state = S_BEGIN1;
      S_BEGIN1:     if (begin_done[1]) next_state = S_TOWER1;
      S_BEGIN2:     if (begin_done[2]) next_state = S_TOWER2;
      S_BEGIN3:     if (begin_done[3]) next_state = S_TOWER3;
      S_TOWER1:     if (tower_done[1]) next_state = S_PLAY1;
      S_TOWER2:     if (tower_done[2]) next_state = S_PLAY2;
      S_TOWER3:     if (tower_done[3]) next_state = S_PLAY3;
      // Loss beats stage clear, and stage clear beats the watchdog.
      S_PLAY1: begin
        if (game_over_feedback) next_state = S_GAME_OVER;
        else if (car_done[1])   next_state = S_DONE1;
        else if (wd_expire) begin
          next_state = S_GAME_OVER;
          wd_fire    = 1'b1;
        end
      end
      S_PLAY2: begin
        if (game_over_feedback) next_state = S_GAME_OVER;
        else if (car_done[2])   next_state = S_DONE2;
        else if (wd_expire) begin
          next_state = S_GAME_OVER;
          wd_fire    = 1'b1;
        end
      end
      S_PLAY3: begin
        if (game_over_feedback) next_state = S_GAME_OVER;
        else if (car_done[3])   next_state = S_DONE3;
        else if (wd_expire) begin
          next_state = S_GAME_OVER;
          wd_fire    = 1'b1;
        end
      end
      S_DONE1:      if (end_done[1] && start_rise) next_state = S_BEGIN2;
      S_DONE2:      if (end_done[2] && start_rise) next_state = S_BEGIN3;
      S_DONE3:      if (end_done[3]) next_state = S_WIN;
      S_WIN,
      S_GAME_OVER:  if (start_rise) next_state = S_WAIT_START;
      default:      next_state = S_WAIT_START;
    endcase
  end

  // NOTE: registered state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_WAIT_START;
      start_q      <= 1'b0;
      stage_num    <= 2'd0;
      timeout_flag <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      state   <= next_state;
      start_q <= start;

      case (next_state)
        S_WAIT_START: stage_num <= 2'd0;
        S_BEGIN1:     stage_num <= 2'd1;
        S_BEGIN2:     stage_num <= 2'd2;
        S_BEGIN3:     stage_num <= 2'd3;
        default:      stage_num <= stage_num;
      endcase

      if (wd_fire)                           timeout_flag <= 1'b1;
      else if (next_state == S_WAIT_START)   timeout_flag <= 1'b0;

      // Staying in play counts up; entering play or any other state restarts at 0.
      if (WD_EN && in_play && next_in_play) wd_cnt <= wd_cnt + TIMER_W'(1);
      else                                  wd_cnt <= '0;
    end
  end

  assign wait_start          = (state == S_WAIT_START);
  assign stage_1_begin       = (state == S_BEGIN1);
  assign stage_2_begin       = (state == S_BEGIN2);
  assign stage_3_begin       = (state == S_BEGIN3);
  assign stage_1_draw_tower  = (state == S_TOWER1);
  assign stage_2_draw_tower  = (state == S_TOWER2);
  assign stage_3_draw_tower  = (state == S_TOWER3);
  assign stage_1_in_progress = (state == S_PLAY1);
  assign stage_2_in_progress = (state == S_PLAY2);
  assign stage_3_in_progress = (state == S_PLAY3);
  assign stage_1_done        = (state == S_DONE1);
  assign stage_2_done        = (state == S_DONE2);
  assign stage_3_done        = (state == S_DONE3);
  assign win                 = (state == S_WIN);
  assign game_over           = (state == S_GAME_OVER);

endmodule
